// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared tile/map types, map geometry and border pattern helpers
package snake_pkg;

   localparam int MAP_ROWS = 12;
   localparam int MAP_COLS = 12;
   localparam int ROW_W    = 4;
   localparam int COL_W    = 4;
   localparam int TILE_W   = 3;

   typedef enum logic [TILE_W-1:0] {
      EMPTY  = 3'd0,
      WALL   = 3'd1,
      SNAKE1 = 3'd2,
      SNAKE2 = 3'd3,
      POINT  = 3'd4
   } tile_t;

   typedef tile_t    [MAP_COLS-1:0] map_row_t;
   typedef map_row_t [MAP_ROWS-1:0] map_s;

   // One row of the freshly initialised map: solid wall on top/bottom rows,
   // wall only at the two edge columns elsewhere.
   function automatic map_row_t border_row(input logic [ROW_W-1:0] r);
      map_row_t row;
      for (int c = 0; c < MAP_COLS; c++) begin
         if (r == ROW_W'(0) || r == ROW_W'(MAP_ROWS-1) || c == 0 || c == MAP_COLS-1)
            row[c] = WALL;
         else
            row[c] = EMPTY;
      end
      return row;
   endfunction

   // Complete bordered map, used as the reset image.
   function automatic map_s border_map();
      map_s m;
      for (int r = 0; r < MAP_ROWS; r++)
         m[r] = border_row(ROW_W'(r));
      return m;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot grant with eligibility mask
module rr_arbiter #(
   parameter int N_REQ = 3,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic [IDX_W-1:0] last,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any
);

   int cand;

   // Search starts one past the last granted index and wraps; first unmasked request wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      cand    = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = (int'(last) + k) % N_REQ;
         if (!any && req[cand] && !mask[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/map_arbiter.sv
// rtl/map_arbiter.sv - tile map storage with vblank-gated round-robin writers and row-wise clear
module map_arbiter
   import snake_pkg::*;
#(
   parameter int N_REQ = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      vblnk,
   input  logic                      clear_req,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*ROW_W-1:0]    wr_row,
   input  logic [N_REQ*COL_W-1:0]    wr_col,
   input  logic [N_REQ*TILE_W-1:0]   wr_tile,
   output logic [N_REQ-1:0]          gnt,
   output tile_t                     rd_tile,
   output logic                      busy,
   output logic                      clear_done,
   output map_s                      map
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [ROW_W-1:0]   row_cnt;
   logic [IDX_W-1:0]   last_idx;

   logic [N_REQ-1:0]   rr_mask;
   logic [N_REQ-1:0]   rr_gnt;
   logic [IDX_W-1:0]   rr_idx;
   logic               rr_any;

   logic               do_grant;
   logic               do_clear_row;
   logic               row_restart;
   logic               row_last;

   logic [ROW_W-1:0]   g_row;
   logic [COL_W-1:0]   g_col;
   tile_t              g_tile;
   logic               g_in_range;

   // A requester granted last cycle is still showing its stale req this cycle,
   // so it is masked; nothing is eligible outside vertical blanking.
   assign rr_mask = gnt | {N_REQ{~vblnk}};

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req     (req),
      .mask    (rr_mask),
      .last    (last_idx),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx),
      .any     (rr_any)
   );

   assign g_row      = wr_row[rr_idx*ROW_W +: ROW_W];
   assign g_col      = wr_col[rr_idx*COL_W +: COL_W];
   assign g_tile     = tile_t'(wr_tile[rr_idx*TILE_W +: TILE_W]);
   assign g_in_range = (g_row < ROW_W'(MAP_ROWS)) && (g_col < COL_W'(MAP_COLS));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next state and per-cycle actions; clear_req beats any pending write request.
   always_comb begin
      state_next   = state;
      do_grant     = 1'b0;
      do_clear_row = 1'b0;
      row_restart  = 1'b0;
      row_last     = 1'b0;
      busy         = 1'b0;
      case (state)
         IDLE: begin
            if (clear_req)
               state_next = CLEAR;
            else if (rr_any)
               do_grant = 1'b1;
         end
         CLEAR: begin
            busy         = 1'b1;
            do_clear_row = 1'b1;
            if (clear_req) begin
               row_restart = 1'b1;
            end else if (row_cnt == ROW_W'(MAP_ROWS-1)) begin
               row_last   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Map storage, grant/read-back registers, clear row counter and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt        <= '0;
         rd_tile    <= EMPTY;
         clear_done <= 1'b0;
         last_idx   <= IDX_W'(N_REQ-1);
         row_cnt    <= '0;
         map        <= border_map();
      end else begin
         gnt        <= do_grant ? rr_gnt : '0;
         clear_done <= row_last;

         if (state == IDLE && clear_req)
            row_cnt <= '0;

         if (do_clear_row) begin
            map[row_cnt] <= border_row(row_cnt);
            if (row_restart || row_last)
               row_cnt <= '0;
            else
               row_cnt <= row_cnt + ROW_W'(1);
         end

         if (do_grant) begin
            last_idx <= rr_idx;
            if (g_in_range) begin
               rd_tile            <= map[g_row][g_col];
               map[g_row][g_col]  <= g_tile;
            end else begin
               rd_tile <= WALL;
            end
         end
      end
   end

endmodule
